byte2_pkt_packer: RTL and testbench

BYTE2_PKT_PACKER -- requirements
Module: byte2_pkt_packer

---
 rtl/byte2_pkt_packer.sv | 141 ++++++++++++++
 tb/tb_byte2_pkt_packer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte2_pkt_packer.sv
// byte2_pkt_packer: packs 1-/2-slot packets into 16x16-bit words, out_valid 1 cycle after the closing accept.
// in_ready drops while a closed word waits (FULL) or a 2-slot packet cannot fit; idle auto-flush under BYTE2_PKR_TIMEOUT_EN.
module byte2_pkt_packer #(
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_len,
  input  logic [29:0]  in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic [15:0]  out_start,
  output logic [4:0]   out_slots
);

  typedef enum logic {FILL, FULL} state_t;

  state_t         state, state_nxt;
  logic [255:0]   acc_data, word_data;
  logic [15:0]    acc_start, word_start;
  logic [4:0]     p, word_slots;
  logic [3:0]     s0, s1;
  logic           accept, pad_close, out_free, timeout_hit;
  logic           close, load_out, clear_acc;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  assign in_ready  = (state == FILL) && !(in_len && (p == 5'd15));
  assign accept    = in_valid && in_ready;
  assign pad_close = (state == FILL) && in_valid && in_len && (p == 5'd15);
  assign out_free  = !out_valid || out_ready;

`ifdef BYTE2_PKR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  assign timeout_hit = (state == FILL) && (p != 5'd0) && !accept
                       && (idle_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if ((state != FILL) || accept || close || (p == 5'd0)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // word_* is the accumulator as it stands after this cycle's accept
  always_comb begin
    state_nxt  = state;
    word_data  = acc_data;
    word_start = acc_start;
    word_slots = p;
    close      = 1'b0;
    load_out   = 1'b0;
    clear_acc  = 1'b0;
    s0         = p[3:0];
    s1         = s0 + 4'd1;
    case (state)
      FILL: begin
        if (accept) begin
          if (in_len) begin
            word_data[{s0, 4'h0} +: 16] = {in_data[13:0], 2'b11};
            word_data[{s1, 4'h0} +: 16] = in_data[29:14];
            word_start[s0]              = 1'b1;
            word_slots                  = p + 5'd2;
          end else begin
            word_data[{s0, 4'h0} +: 16] = {in_data[13:0], 2'b01};
            word_slots                  = p + 5'd1;
          end
        end
        close = (word_slots == 5'd16) || (flush && (word_slots != 5'd0))
                || pad_close || timeout_hit;
        if (close) begin
          if (out_free) begin
            load_out  = 1'b1;
            clear_acc = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (out_free) begin
          load_out  = 1'b1;
          clear_acc = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      acc_data  <= '0;
      acc_start <= '0;
      p         <= '0;
    end else begin
      state <= state_nxt;
      if (clear_acc) begin
        acc_data  <= '0;
        acc_start <= '0;
        p         <= '0;
      end else begin
        acc_data  <= word_data;
        acc_start <= word_start;
        p         <= word_slots;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_start <= '0;
      out_slots <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_data  <= word_data;
      out_start <= word_start;
      out_slots <= word_slots;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte2_pkt_packer.sv
// Directed bench for byte2_pkt_packer: hand-built expected words compared against words taken off the output port.
module tb_byte2_pkt_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_len, flush;
  logic [29:0]  in_data;
  logic         out_valid, out_ready;
  logic [255:0] out_data;
  logic [15:0]  out_start;
  logic [4:0]   out_slots;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [255:0] d;
    logic [15:0]  s;
    logic [4:0]   n;
  } word_t;
  word_t q[$];

  byte2_pkt_packer #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_len(in_len), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_start(out_start), .out_slots(out_slots)
  );

  always #5 clk = ~clk;

  // words are taken at the negedge before the edge that consumes them
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      word_t w;
      w.d = out_data; w.s = out_start; w.n = out_slots;
      q.push_back(w);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic len, input logic [29:0] d, input logic fl, output int stalls);
    logic took;
    took = 1'b0;
    stalls = 0;
    in_valid = 1'b1; in_len = len; in_data = d; flush = fl;
    for (int i = 0; i < 64 && !took; i++) begin
      @(negedge clk);
      took = in_ready;
      if (!took) stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_len = 1'b0; flush = 1'b0;
    if (!took) begin
      vectors++; miscompares++;
      $display("FAIL push_accept: in_ready never high within 64 cycles, required accept");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_len = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    step(3);
    vectors++;
    if ({out_valid, out_data, out_start, out_slots} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b s=%h n=%0d, required all zero", out_valid, out_start, out_slots);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_one_slot_full;
    logic [255:0] exp;
    int st;
    q.delete();
    exp = '0;
    for (int k = 0; k < 16; k++) begin
      exp[16*k +: 16] = 16'((k << 2) | 1);
      push(1'b0, 30'(k), 1'b0, st);
      if (k == 14) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL one_slot_early_valid: got %b, required 0", out_valid);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL one_slot_latency: out_valid %b one cycle after 16th accept, required 1", out_valid);
    end
    step(1);
    vectors++;
    if (q.size() != 1) begin
      miscompares++;
      $display("FAIL one_slot_count: got %0d words, required 1", q.size());
    end else begin
      vectors++;
      if (q[0].d !== exp || q[0].s !== 16'h0000 || q[0].n !== 5'd16) begin
        miscompares++;
        $display("FAIL one_slot_word: got %h s=%h n=%0d, required %h s=0000 n=16", q[0].d, q[0].s, q[0].n, exp);
      end
    end
  endtask

  task automatic test_pad_slot15;
    logic [255:0] exp1, exp2;
    int st;
    q.delete();
    exp1 = '0;
    for (int k = 0; k < 15; k++) begin
      exp1[16*k +: 16] = {14'(100 + k), 2'b01};
      push(1'b0, 30'(100 + k), 1'b0, st);
    end
    push(1'b1, {16'hBEEF, 14'h1234}, 1'b0, st);
    vectors++;
    if (st != 1) begin
      miscompares++;
      $display("FAIL pad_stall: in_ready low %0d cycles, required 1", st);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(2);
    exp2 = '0;
    exp2[15:0]  = 16'h48D3;
    exp2[31:16] = 16'hBEEF;
    vectors++;
    if (q.size() != 2) begin
      miscompares++;
      $display("FAIL pad_count: got %0d words, required 2", q.size());
    end else begin
      vectors++;
      if (q[0].d !== exp1 || q[0].s !== 16'h0000 || q[0].n !== 5'd15) begin
        miscompares++;
        $display("FAIL pad_word1: got %h s=%h n=%0d, required %h s=0000 n=15", q[0].d, q[0].s, q[0].n, exp1);
      end
      vectors++;
      if (q[1].d !== exp2 || q[1].s !== 16'h0001 || q[1].n !== 5'd2) begin
        miscompares++;
        $display("FAIL pad_word2: got %h s=%h n=%0d, required %h s=0001 n=2", q[1].d, q[1].s, q[1].n, exp2);
      end
    end
  endtask

  task automatic test_two_slot;
    logic [255:0] exp;
    int st;
    q.delete();
    exp = '0;
    for (int k = 0; k < 8; k++) begin
      exp[32*k +: 16]      = {14'(14'h0100 + k), 2'b11};
      exp[32*k + 16 +: 16] = 16'(16'hA000 + k);
      push(1'b1, {16'(16'hA000 + k), 14'(14'h0100 + k)}, 1'b0, st);
    end
    step(1);
    vectors++;
    if (q.size() != 1) begin
      miscompares++;
      $display("FAIL two_slot_count: got %0d words, required 1", q.size());
    end else begin
      vectors++;
      if (q[0].d !== exp || q[0].s !== 16'h5555 || q[0].n !== 5'd16) begin
        miscompares++;
        $display("FAIL two_slot_word: got %h s=%h n=%0d, required %h s=5555 n=16", q[0].d, q[0].s, q[0].n, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] expa, expb;
    int st;
    q.delete();
    expa = '0; expb = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k < 16) expa[16*k +: 16] = {14'(200 + k), 2'b01};
      else        expb[16*(k-16) +: 16] = {14'(200 + k), 2'b01};
      push(1'b0, 30'(200 + k), 1'b0, st);
    end
    step(1);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_in_ready: got %b while second word pending, required 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== expa || out_slots !== 5'd16) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got v=%b %h n=%0d, required v=1 %h n=16", i, out_valid, out_data, out_slots, expa);
      end
      step(1);
    end
    out_ready = 1'b1;
    step(4);
    vectors++;
    if (q.size() != 2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words, required 2", q.size());
    end else begin
      vectors++;
      if (q[0].d !== expa || q[1].d !== expb || q[1].n !== 5'd16) begin
        miscompares++;
        $display("FAIL bp_order: got %h / %h, required %h / %h", q[0].d, q[1].d, expa, expb);
      end
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume: in_ready %b after drain, required 1", in_ready);
    end
  endtask

  task automatic test_flush;
    logic [255:0] exp;
    int st;
    q.delete();
    exp = '0;
    for (int k = 0; k < 4; k++) begin
      exp[16*k +: 16] = {14'(14'h0301 + k), 2'b01};
      push(1'b0, 30'(14'h0301 + k), k == 3, st);
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_latency: out_valid %b after accept+flush, required 1", out_valid);
    end
    step(2);
    vectors++;
    if (q.size() != 1) begin
      miscompares++;
      $display("FAIL flush_count: got %0d words, required 1", q.size());
    end else begin
      vectors++;
      if (q[0].d !== exp || q[0].s !== 16'h0000 || q[0].n !== 5'd4) begin
        miscompares++;
        $display("FAIL flush_word: got %h s=%h n=%0d, required %h s=0000 n=4", q[0].d, q[0].s, q[0].n, exp);
      end
    end
    q.delete();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(5);
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_empty: got %0d words v=%b, required 0 words v=0", q.size(), out_valid);
    end
  endtask

  task automatic test_idle_and_reset;
    int st;
    q.delete();
    push(1'b0, 30'h11, 1'b0, st);
    push(1'b0, 30'h22, 1'b0, st);
`ifdef BYTE2_PKR_TIMEOUT_EN
    step(7);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: out_valid %b after 7 idle cycles, required 0", out_valid);
    end
    step(1);
    vectors++;
    if (out_valid !== 1'b1 || out_slots !== 5'd2 || out_data[31:0] !== 32'h0089_0045) begin
      miscompares++;
      $display("FAIL timeout_word: got v=%b n=%0d lo=%h, required v=1 n=2 lo=00890045", out_valid, out_slots, out_data[31:0]);
    end
    step(2);
`else
    step(20);
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout: got %0d words v=%b after idle, required none", q.size(), out_valid);
    end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(2);
`endif
    q.delete();
    push(1'b0, 30'h33, 1'b0, st);
    push(1'b0, 30'h44, 1'b0, st);
    rst_n = 1'b0;
    step(2);
    vectors++;
    if (out_valid !== 1'b0 || out_slots !== 5'd0) begin
      miscompares++;
      $display("FAIL midreset_out: got v=%b n=%0d, required v=0 n=0", out_valid, out_slots);
    end
    rst_n = 1'b1;
    step(20);
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_discard: got %0d words v=%b, required none", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_one_slot_full();
    test_pad_slot15();
    test_two_slot();
    test_backpressure();
    test_flush();
    test_idle_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
